// File: rtl/definitions.sv
// rtl/definitions.sv - shared types and constants for the fetch/decode stage and ALU
// Purpose: ALU op encoding, fetch FSM state encoding, special instruction patterns.
// Ports: none (package).
package definitions;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    SLL = 3'd2,
    SRL = 3'd3,
    EQU = 3'd4,
    GTR = 3'd5,
    AND = 3'd6,
    XOR = 3'd7
  } ALU_Ops;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    HALT   = 2'd3
  } FetchState_t;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;
  localparam logic [4:0] BRZ_PREFIX = 5'b11100;

endpackage

// File: rtl/fetch_decoder.sv
// rtl/fetch_decoder.sv - combinational decode of a captured 9-bit instruction
// Purpose: split an instruction into ALU control, register address and control-flow flags.
// Ports:
//   instr_out  in   9  captured instruction
//   alu_op     out  3  ALU op (ADD for non-ALU instructions)
//   is_alu     out  1  instruction is an ALU op (bit 8 clear)
//   reg_addr   out  4  register-file read address
//   is_halt    out  1  instruction is HALT
//   is_brz     out  1  instruction is a zero-flag branch
module fetch_decoder
  import definitions::*;
(
  input  logic [8:0] instr_out,
  output ALU_Ops     alu_op,
  output logic       is_alu,
  output logic [3:0] reg_addr,
  output logic       is_halt,
  output logic       is_brz
);

  always_comb begin
    is_alu   = ~instr_out[8];
    alu_op   = ADD;
    if (!instr_out[8]) begin
      alu_op = ALU_Ops'(instr_out[7:5]);
    end
    reg_addr = instr_out[3:0];
    is_halt  = (instr_out == HALT_INSTR);
    is_brz   = (instr_out[8:4] == BRZ_PREFIX);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch/decode stage: PC, instruction register, FETCH/DECODE FSM
// Purpose: runs FETCH/DECODE from a start pulse until HALT, resolving zero-flag branches.
// Optional feature: define FETCH_CYCLE_CNT_EN to build the saturating busy-cycle counter.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  restart pulse (honoured in IDLE/HALT only)
//   stall                  hold DECODE while downstream is not ready
//   zero_in                zero flag sampled in DECODE for BRZ
//   branch_target [PC_W]   absolute BRZ target
//   imem_addr [PC_W]       ROM address (= pc)
//   imem_data [9]          ROM data, captured at the end of FETCH
//   instr_out [9]          captured instruction
//   instr_valid            high in every DECODE cycle
//   alu_op [3], is_alu, reg_addr [4]  decode of instr_out
//   pc_out [PC_W]          current PC
//   halted                 high in HALT
//   cycle_count [16]       FETCH/DECODE cycle count (0 when the counter is not built)
module fetch_unit
  import definitions::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            zero_in,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr_out,
  output logic            instr_valid,
  output logic [2:0]      alu_op,
  output logic            is_alu,
  output logic [3:0]      reg_addr,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output logic [15:0]     cycle_count
);

  FetchState_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      instr_q, instr_d;

  ALU_Ops alu_op_w;
  logic   is_halt_w;
  logic   is_brz_w;

  fetch_decoder u_decoder (
    .instr_out (instr_q),
    .alu_op    (alu_op_w),
    .is_alu    (is_alu),
    .reg_addr  (reg_addr),
    .is_halt   (is_halt_w),
    .is_brz    (is_brz_w)
  );

  // A start pulse only restarts the machine when it is parked.
  logic start_ok;
  assign start_ok = start && ((state_q == IDLE) || (state_q == HALT));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = FETCH;
        end
      end
      FETCH: begin
        instr_d = imem_data;
        state_d = DECODE;
      end
      DECODE: begin
        // Stall freezes everything, including a pending HALT.
        if (!stall) begin
          if (is_halt_w) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
            if (is_brz_w && zero_in) begin
              pc_d = branch_target;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (((state_q == FETCH) || (state_q == DECODE)) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = 16'd0;
`endif

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = (state_q == DECODE);
  assign halted      = (state_q == HALT);
  assign alu_op      = alu_op_w;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and decode stage sitting directly upstream of the 8-bit ALU. It owns the program counter and issues addresses to a synchronous instruction ROM. It decodes each 9-bit instruction into the ALU `op_ctrl` code and register address, and resolves zero-flag branches. It runs a multi-cycle FETCH/DECODE loop from a `start` pulse until it decodes the HALT instruction.

## Interface
- `PC_W`, default 10: program counter / ROM address width.
- `START_PC`, default 0: PC loaded on `start`.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- `stall`  in  1  holds the DECODE state (downstream not ready).
- `zero_in`  in  1  latched zero flag from the execute side; sampled in DECODE.
- `branch_target`  in  PC_W  absolute target for a taken BRZ.
- `imem_addr`  out  PC_W  ROM address; equals `pc`.
- `imem_data`  in  9  ROM data; valid one cycle after `imem_addr` is presented.
- `instr_out`  out  9  captured instruction.
- `instr_valid`  out  1  high in every DECODE cycle.
- `alu_op`  out  3  ALU op code in the ALU_Ops encoding: ADD=0, SUB=1, SLL=2, SRL=3, EQU=4, GTR=5, AND=6, XOR=7.
- `is_alu`  out  1  decoded instruction is an ALU op.
- `reg_addr`  out  4  register-file read address (`instr[3:0]`).
- `pc_out`  out  PC_W  current PC.
- `halted`  out  1  high while in HALT.
- `cycle_count`  out  16  see Configuration.

## Operation
- States:
  - IDLE (reset state).
  - FETCH.
  - DECODE.
  - HALT.
- IDLE:
  - `start` → pc <= START_PC, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH, one cycle:
  - `imem_addr` = pc.
  - At the end of the cycle, `instr_out` <= `imem_data`. The ROM output appears on the edge closing this cycle and is registered at that edge.
  - Go to DECODE.
- DECODE:
  - `instr_valid` = 1; decode outputs are combinational from `instr_out`.
  - If `stall` = 1: hold state, pc, and instr_out.
  - If `stall` = 0, evaluate in this priority order:
    1. HALT (`instr_out` == 9'h1FF) → go to HALT; pc is unchanged.
    2. BRZ (`instr_out[8:4]` == 5'b11100) with `zero_in` = 1 → pc <= `branch_target`, go to FETCH.
    3. Otherwise → pc <= pc + 1 (mod 2^PC_W), go to FETCH.
- HALT:
  - `halted` = 1.
  - `start` → pc <= START_PC, go to FETCH (restart).
  - Otherwise stay in HALT.
- Decode rules:
  - `instr_out[8]` = 0 → `is_alu` = 1, `alu_op` = `instr_out[7:5]`.
  - `instr_out[8]` = 1 → `is_alu` = 0, `alu_op` = ADD (0).
  - `reg_addr` = `instr_out[3:0]` always.
- `start` in FETCH or DECODE is ignored.
- A BRZ with `zero_in` = 0 falls through to pc + 1.

## Timing
- Reset values:
  - state = IDLE, pc = START_PC, instr_out = 0.
  - instr_valid = 0, halted = 0, cycle_count = 0.
  - Decode outputs derive from instr_out = 0: is_alu = 1, alu_op = 0, reg_addr = 0.
- Throughput: one instruction per 2 cycles (FETCH + DECODE), plus one cycle per stall cycle.
- Latency:
  - `start` edge → first `instr_valid` two cycles later.
  - Taken branch → target instruction valid two cycles after the DECODE cycle that resolved it.
- PC wrap: pc = 2^PC_W − 1 with a non-branch instruction → next pc = 0, no error.
- `reset` mid-operation returns to IDLE asynchronously; outputs take reset values without waiting for `clk`.
- `stall` and HALT in the same DECODE cycle: the stall wins; HALT is entered on the first non-stalled cycle.

## Configuration
- `FETCH_CYCLE_CNT_EN` defined:
  - `cycle_count` increments every cycle in FETCH or DECODE, saturating at 16'hFFFF.
  - It clears to 0 on an honoured `start`.
  - It holds its value in HALT and IDLE.
- Not defined: `cycle_count` is tied to 0 and no counter logic is synthesised.

## Structure
- Shared package `definitions` holds:
  - existing `ALU_Ops` enum (used for `alu_op`);
  - new `FetchState_t` enum (IDLE, FETCH, DECODE, HALT);
  - constants `HALT_INSTR` = 9'h1FF and `BRZ_PREFIX` = 5'b11100.
- One combinational sub-module, `fetch_decoder`: `instr_out` in; `alu_op`, `is_alu`, `reg_addr`, `is_halt`, `is_brz` out.
- The top level holds the FSM, PC, instruction register and optional counter.

## Test plan
- Reset, then `start`, ROM[0] = 9'h045 (ALU, op 2) → DECODE cycle 2 clocks later: `is_alu` = 1, `alu_op` = SLL (2), `reg_addr` = 5, pc = 0 → 1.
- Sequence ROM[0..2] = ALU ops, ROM[3] = 9'h1FF → `halted` rises after the 4th DECODE, pc holds 3. `FETCH_CYCLE_CNT_EN` build: `cycle_count` = 8.
- BRZ 9'h1C0 at pc = 5, `branch_target` = 20: `zero_in` = 1 → next fetch address 20; `zero_in` = 0 → next fetch address 6.
- `stall` high for 3 cycles during DECODE of a HALT → `instr_valid` high 4 cycles, pc unchanged, HALT entered after `stall` drops.
- PC_W = 4, run straight-line code to pc = 15 → next `imem_addr` = 0.
- Assert `reset` asynchronously mid-DECODE → state IDLE, `instr_valid` = 0, pc = START_PC before the next `clk` edge. A `start` pulse issued in FETCH is ignored.
